// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: operand forwarding select, load-use / mult-div hazard
// detection, mult/div busy tracking and a saturating stall counter.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   ex_src, id_src  packed source specifiers, operand k at [k*REG_W +: REG_W]
//   fwd_we, fwd_rd  per forwarding stage write enable / destination (0 = MEM)
//   ex_memread      EX instruction is a load; ex_rd is its destination
//   md_start        mult/div issued from EX this cycle
//   id_uses_md      ID instruction needs HI/LO or the mult/div unit
//   fwd_sel         per-operand mux select (0 = regfile, i+1 = stage i), comb
//   stall, flush_ex hazard outputs, comb
//   md_busy         mult/div unit busy (decoded from the busy counter)
//   md_err          registered one-cycle pulse: md_start while busy
//   stall_cnt       saturating count of stalled cycles
module hazard_fwd_unit #(
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned NUM_FWD = 2,
   parameter int unsigned REG_W   = 5,
   parameter int unsigned MD_LAT  = 4,
   parameter int unsigned CNT_W   = 16,
   localparam int unsigned SEL_W  = $clog2(NUM_FWD + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_SRC*REG_W-1:0]   ex_src,
   input  logic [NUM_SRC*REG_W-1:0]   id_src,
   input  logic [NUM_FWD-1:0]         fwd_we,
   input  logic [NUM_FWD*REG_W-1:0]   fwd_rd,
   input  logic                       ex_memread,
   input  logic [REG_W-1:0]           ex_rd,
   input  logic                       md_start,
   input  logic                       id_uses_md,
   output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
   output logic                       stall,
   output logic                       flush_ex,
   output logic                       md_busy,
   output logic                       md_err,
   output logic [CNT_W-1:0]           stall_cnt
);

   localparam int unsigned MD_CNT_W = 8;

   logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
   logic                md_err_q, md_err_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
   logic                load_use;
   logic                md_hz;

   // Forward select: scan oldest to youngest so the youngest match wins.
   always_comb begin
      fwd_sel = '0;
      for (int k = 0; k < int'(NUM_SRC); k++) begin
         for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
            if (fwd_we[i] &&
                (fwd_rd[i*REG_W +: REG_W] == ex_src[k*REG_W +: REG_W]) &&
                (fwd_rd[i*REG_W +: REG_W] != '0)) begin
               fwd_sel[k*SEL_W +: SEL_W] = SEL_W'(i + 1);
            end
         end
      end
   end

   // Load-use hazard against any ID source operand.
   always_comb begin
      load_use = 1'b0;
      for (int k = 0; k < int'(NUM_SRC); k++) begin
         if (ex_memread && (ex_rd != '0) && (id_src[k*REG_W +: REG_W] == ex_rd)) begin
            load_use = 1'b1;
         end
      end
   end

   assign md_busy  = (md_cnt_q != '0);
   assign md_hz    = id_uses_md && md_busy;
   assign stall    = load_use || md_hz;
   assign flush_ex = stall;

   // Next state: a start while busy is flagged but never restarts the count.
   always_comb begin
      md_cnt_d    = md_cnt_q;
      md_err_d    = 1'b0;
      stall_cnt_d = stall_cnt_q;
      if (md_start && !md_busy) begin
         md_cnt_d = MD_CNT_W'(MD_LAT);
      end else if (md_busy) begin
         md_cnt_d = md_cnt_q - MD_CNT_W'(1);
      end
      md_err_d = md_start && md_busy;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         md_cnt_q    <= '0;
         md_err_q    <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         md_cnt_q    <= md_cnt_d;
         md_err_q    <= md_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign md_err    = md_err_q;
   assign stall_cnt = stall_cnt_q;

endmodule
